// File: rtl/userio_joy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : userio_joy_pkg                                                   |
// | Desc    : Shared types and bit layout for the DB15 user-port joystick reader|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package userio_joy_pkg;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        DONE     = 3'd3,
        GAP      = 3'd4
    } joy_state_e;

    // Direction bit positions inside a joystick word
    localparam int JOY_R = 0;
    localparam int JOY_L = 1;
    localparam int JOY_D = 2;
    localparam int JOY_U = 3;

    localparam int JOY_WORD_W               = 16;
    localparam int DEFAULT_NBITS_PER_PLAYER = 12;

endpackage
`default_nettype wire

// File: rtl/userio_bit_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : userio_bit_filter                                                |
// | Desc    : Per-bit frame debounce; used only with USERIO_DB15_DEBOUNCE_EN    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module userio_bit_filter #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic update,
    input  logic raw_bit,
    output logic filt_bit
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_FRAMES);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_filt;
    logic [c_cnt_w-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    // The counter only ever holds disagreeing frames in a row, so it saturates at the toggle point
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (update) begin
            if (raw_bit == r_filt) begin
                r_cnt <= '0;
            end else if (w_cnt_inc == c_cnt_max) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign filt_bit = r_filt;

endmodule
`default_nettype wire

// File: rtl/userio_db15_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : userio_db15_scanner                                              |
// | Desc    : 74HC165 chain reader for the two-player DB15 adapter.            |
// |           Optional debounce with `define USERIO_DB15_DEBOUNCE_EN.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module userio_db15_scanner
    import userio_joy_pkg::*;
#(
    parameter int CLK_DIV          = 32,
    parameter int NBITS_PER_PLAYER = DEFAULT_NBITS_PER_PLAYER,
    parameter int GAP_TICKS        = 64,
    parameter int DEBOUNCE_FRAMES  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  joy_data,
    output logic                  joy_clk,
    output logic                  joy_load,
    output logic [JOY_WORD_W-1:0] joystick1,
    output logic [JOY_WORD_W-1:0] joystick2,
    output logic                  frame_done
);

    localparam int c_nbits  = 2 * NBITS_PER_PLAYER;
    localparam int c_div_w  = $clog2(CLK_DIV);
    localparam int c_bit_w  = $clog2(c_nbits);
    localparam int c_tcnt_w = $clog2((GAP_TICKS > 2) ? GAP_TICKS : 2);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(c_nbits - 1);
    localparam logic [c_tcnt_w-1:0] c_load_last = c_tcnt_w'(1);
    localparam logic [c_tcnt_w-1:0] c_gap_last  = c_tcnt_w'(GAP_TICKS - 1);

    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("CLK_DIV must be at least 2");
    end
    if (GAP_TICKS < 1) begin : g_chk_gap
        $error("GAP_TICKS must be at least 1");
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_FRAMES must be at least 1");
    end
    if (NBITS_PER_PLAYER > JOY_WORD_W) begin : g_chk_width
        $error("NBITS_PER_PLAYER exceeds the joystick word");
    end

    joy_state_e          r_state;
    joy_state_e          w_state_next;
    logic [c_div_w-1:0]  r_div;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [c_tcnt_w-1:0] w_tcnt_next;
    logic [c_bit_w-1:0]  r_bit;
    logic [c_bit_w-1:0]  w_bit_next;
    logic [c_nbits-1:0]  r_shreg;
    logic                r_joy_clk;
    logic                r_joy_load;
    logic                r_frame_done;
    logic                w_tick;
    logic                w_sample;
    logic [c_nbits-1:0]  w_pressed;

    // The divider freezes during DONE, which makes the frame period exactly one clk longer than a tick multiple
    assign w_tick = (r_div == c_div_last) && (r_state != DONE);

    always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = r_tcnt;
        w_bit_next   = r_bit;
        w_sample     = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_tick) begin
                    if (r_tcnt == c_load_last) begin
                        w_tcnt_next  = '0;
                        w_state_next = SHIFT_LO;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                if (w_tick) begin
                    w_sample     = 1'b1;
                    w_state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_tick) begin
                    if (r_bit == c_bit_last) begin
                        w_bit_next   = '0;
                        w_state_next = DONE;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_state_next = SHIFT_LO;
                    end
                end
            end
            DONE: begin
                w_state_next = GAP;
            end
            GAP: begin
                if (w_tick) begin
                    if (r_tcnt == c_gap_last) begin
                        w_tcnt_next  = '0;
                        w_state_next = LOAD;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= LOAD;
            r_div        <= '0;
            r_tcnt       <= '0;
            r_bit        <= '0;
            r_shreg      <= '1;
            r_joy_clk    <= 1'b0;
            r_joy_load   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tcnt  <= w_tcnt_next;
            r_bit   <= w_bit_next;
            if (r_state != DONE) begin
                r_div <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
            end
            if (w_sample) begin
                r_shreg[r_bit] <= joy_data;
            end
            // Pin levels follow the state one clk late so the chain sees clean, glitch-free edges
            r_joy_load   <= (r_state != LOAD);
            r_joy_clk    <= (r_state == SHIFT_HI);
            r_frame_done <= (r_state == DONE);
        end
    end

`ifdef USERIO_DB15_DEBOUNCE_EN
    for (genvar gi = 0; gi < c_nbits; gi++) begin : g_filter
        userio_bit_filter #(
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
        ) u_filter (
            .clk      (clk),
            .reset_n  (reset_n),
            .update   (r_state == DONE),
            .raw_bit  (~r_shreg[gi]),
            .filt_bit (w_pressed[gi])
        );
    end
`else
    logic [c_nbits-1:0] r_pressed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pressed <= '0;
        end else if (r_state == DONE) begin
            r_pressed <= ~r_shreg;
        end
    end

    assign w_pressed = r_pressed;
`endif

    assign joy_clk    = r_joy_clk;
    assign joy_load   = r_joy_load;
    assign frame_done = r_frame_done;
    assign joystick1  = JOY_WORD_W'(w_pressed[NBITS_PER_PLAYER-1:0]);
    assign joystick2  = JOY_WORD_W'(w_pressed[c_nbits-1:NBITS_PER_PLAYER]);

endmodule
`default_nettype wire

// File: tb/tb_userio_db15_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_userio_db15_scanner                                           |
// | Desc    : Self-checking bench with a 165-chain model and frame-level model  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_userio_db15_scanner;

    localparam int CLK_DIV   = 4;
    localparam int NBPP      = 12;
    localparam int NBITS     = 2 * NBPP;
    localparam int GAP_TICKS = 4;
    localparam int DEBOUNCE  = 3;
    localparam int PERIOD    = (2 + 2 * NBITS + GAP_TICKS) * CLK_DIV + 1;
    localparam int LIMIT     = 2 * PERIOD;
`ifdef USERIO_DB15_DEBOUNCE_EN
    localparam int SETTLE = DEBOUNCE;
`else
    localparam int SETTLE = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_data;
    logic        joy_clk;
    logic        joy_load;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    userio_db15_scanner #(
        .CLK_DIV          (CLK_DIV),
        .NBITS_PER_PLAYER (NBPP),
        .GAP_TICKS        (GAP_TICKS),
        .DEBOUNCE_FRAMES  (DEBOUNCE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy_data   (joy_data),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done)
    );

    // 165 chain: parallel load on falling load, each rising shift clock exposes the next bit
    logic [NBITS-1:0] pattern = '1;
    logic [NBITS-1:0] latched = '1;
    int               idx     = NBITS;

    always @(negedge joy_load) begin
        latched = pattern;
        idx     = 0;
    end
    always @(posedge joy_clk) begin
        if (joy_load === 1'b1) idx = idx + 1;
    end
    assign joy_data = (idx < NBITS) ? latched[idx] : 1'b1;

    // Frame-level reference: what the core should present after each completed frame
    logic [NBITS-1:0] exp_pressed;
    int               db_cnt [NBITS];

    task automatic model_reset();
        exp_pressed = '0;
        for (int i = 0; i < NBITS; i++) db_cnt[i] = 0;
    endtask

    task automatic model_frame(input logic [NBITS-1:0] pat);
        for (int i = 0; i < NBITS; i++) begin
            logic raw;
            raw = ~pat[i];
`ifdef USERIO_DB15_DEBOUNCE_EN
            if (raw != exp_pressed[i]) begin
                db_cnt[i] = db_cnt[i] + 1;
                if (db_cnt[i] == DEBOUNCE) begin
                    exp_pressed[i] = raw;
                    db_cnt[i]      = 0;
                end
            end else begin
                db_cnt[i] = 0;
            end
`else
            exp_pressed[i] = raw;
`endif
        end
    endtask

    function automatic logic [15:0] exp_word(input int p);
        return 16'(exp_pressed[p*NBPP +: NBPP]);
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (frame_done !== 1'b1 && n < LIMIT);
    endtask

    task automatic run_frame(input logic [NBITS-1:0] pat, output int n, output bit ok);
        pattern = pat;
        wait_done(n);
        ok = (frame_done === 1'b1);
        if (ok) model_frame(pat);
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 5;
        if (joy_load !== 1'b1)   begin n_fail++; $display("FAIL por_load got=%b exp=1", joy_load); end
        if (joy_clk !== 1'b0)    begin n_fail++; $display("FAIL por_clk got=%b exp=0", joy_clk); end
        if (joystick1 !== 16'h0) begin n_fail++; $display("FAIL por_j1 got=%h exp=0000", joystick1); end
        if (joystick2 !== 16'h0) begin n_fail++; $display("FAIL por_j2 got=%h exp=0000", joystick2); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL por_done got=%b exp=0", frame_done); end
        reset_n = 1'b1;
        model_reset();
        for (int f = 0; f < SETTLE; f++) begin
            run_frame(24'h0F00F0, n, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL reset_pre_timeout got=none exp=frame_done"); end
        end
        n_cmp++;
        if (joystick1 !== exp_word(0)) begin n_fail++; $display("FAIL reset_pre_j1 got=%h exp=%h", joystick1, exp_word(0)); end
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp += 5;
            if (joy_load !== 1'b1)   begin n_fail++; $display("FAIL rst_load c=%0d got=%b exp=1", c, joy_load); end
            if (joy_clk !== 1'b0)    begin n_fail++; $display("FAIL rst_clk c=%0d got=%b exp=0", c, joy_clk); end
            if (joystick1 !== 16'h0) begin n_fail++; $display("FAIL rst_j1 c=%0d got=%h exp=0000", c, joystick1); end
            if (joystick2 !== 16'h0) begin n_fail++; $display("FAIL rst_j2 c=%0d got=%h exp=0000", c, joystick2); end
            if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done c=%0d got=%b exp=0", c, frame_done); end
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_released();
        int n;
        bit ok;
        for (int f = 0; f <= SETTLE; f++) begin
            run_frame('1, n, ok);
            n_cmp += 3;
            if (!ok) begin n_fail++; $display("FAIL idle_timeout got=none exp=frame_done"); end
            if (joystick1 !== 16'h0) begin n_fail++; $display("FAIL idle_j1 got=%h exp=0000", joystick1); end
            if (joystick2 !== 16'h0) begin n_fail++; $display("FAIL idle_j2 got=%h exp=0000", joystick2); end
            if (f > 0) begin
                n_cmp++;
                if (n != PERIOD) begin n_fail++; $display("FAIL idle_period got=%0d exp=%0d", n, PERIOD); end
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_width got=%b exp=0", frame_done); end
    endtask

    task automatic test_single_press();
        int n;
        bit ok;
        logic [NBITS-1:0] pat;
        pat = '1;
        pat[3] = 1'b0;
        pat[NBPP + 11] = 1'b0;
        for (int f = 0; f < SETTLE; f++) begin
            run_frame(pat, n, ok);
            n_cmp += 3;
            if (!ok) begin n_fail++; $display("FAIL press_timeout got=none exp=frame_done"); end
            if (joystick1 !== exp_word(0)) begin n_fail++; $display("FAIL press_j1_model got=%h exp=%h", joystick1, exp_word(0)); end
            if (joystick2 !== exp_word(1)) begin n_fail++; $display("FAIL press_j2_model got=%h exp=%h", joystick2, exp_word(1)); end
        end
        n_cmp += 2;
        if (joystick1 !== 16'h0008) begin n_fail++; $display("FAIL press_p1_up got=%h exp=0008", joystick1); end
        if (joystick2 !== 16'h0800) begin n_fail++; $display("FAIL press_p2_b11 got=%h exp=0800", joystick2); end
    endtask

    task automatic test_stuck_pins();
        int n;
        bit ok;
        for (int f = 0; f < SETTLE; f++) run_frame('0, n, ok);
        n_cmp += 3;
        if (!ok) begin n_fail++; $display("FAIL stuck_timeout got=none exp=frame_done"); end
        if (joystick1 !== 16'h0FFF) begin n_fail++; $display("FAIL stuck_low_j1 got=%h exp=0fff", joystick1); end
        if (joystick2 !== 16'h0FFF) begin n_fail++; $display("FAIL stuck_low_j2 got=%h exp=0fff", joystick2); end
        for (int f = 0; f < SETTLE; f++) run_frame('1, n, ok);
        n_cmp += 2;
        if (joystick1 !== 16'h0) begin n_fail++; $display("FAIL stuck_high_j1 got=%h exp=0000", joystick1); end
        if (joystick2 !== 16'h0) begin n_fail++; $display("FAIL stuck_high_j2 got=%h exp=0000", joystick2); end
    endtask

    task automatic test_debounce();
        int n;
        bit ok;
        logic [4:0] lows;
        logic [4:0] want;
        lows = 5'b11101;
`ifdef USERIO_DB15_DEBOUNCE_EN
        want = 5'b10000;
`else
        want = 5'b11101;
`endif
        for (int f = 0; f < 5; f++) begin
            logic [NBITS-1:0] pat;
            pat = '1;
            pat[0] = ~lows[f];
            run_frame(pat, n, ok);
            n_cmp += 2;
            if (joystick1[0] !== want[f]) begin n_fail++; $display("FAIL deb_bit0 f=%0d got=%b exp=%b", f, joystick1[0], want[f]); end
            if (joystick1 !== exp_word(0)) begin n_fail++; $display("FAIL deb_model f=%0d got=%h exp=%h", f, joystick1, exp_word(0)); end
        end
    endtask

    task automatic test_random();
        int n;
        bit ok;
        for (int f = 0; f < 12; f++) begin
            run_frame(NBITS'($urandom), n, ok);
            n_cmp += 3;
            if (n != PERIOD) begin n_fail++; $display("FAIL rnd_period f=%0d got=%0d exp=%0d", f, n, PERIOD); end
            if (joystick1 !== exp_word(0)) begin n_fail++; $display("FAIL rnd_j1 f=%0d got=%h exp=%h", f, joystick1, exp_word(0)); end
            if (joystick2 !== exp_word(1)) begin n_fail++; $display("FAIL rnd_j2 f=%0d got=%h exp=%h", f, joystick2, exp_word(1)); end
        end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        int rises;
        int m;
        bit ok;
        logic prev;
        logic [NBITS-1:0] pat;
        for (int f = 0; f < SETTLE; f++) run_frame('0, n, ok);
        pat = NBITS'($urandom);
        pattern = pat;
        rises = 0;
        n = 0;
        prev = joy_clk;
        while (rises < 11 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (joy_clk && !prev) rises++;
            prev = joy_clk;
        end
        n_cmp++;
        if (rises != 11) begin n_fail++; $display("FAIL mid_rises got=%0d exp=11", rises); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp += 4;
        if (joy_clk !== 1'b0)    begin n_fail++; $display("FAIL mid_clk got=%b exp=0", joy_clk); end
        if (joy_load !== 1'b1)   begin n_fail++; $display("FAIL mid_load got=%b exp=1", joy_load); end
        if (joystick1 !== 16'h0) begin n_fail++; $display("FAIL mid_j1 got=%h exp=0000", joystick1); end
        if (joystick2 !== 16'h0) begin n_fail++; $display("FAIL mid_j2 got=%h exp=0000", joystick2); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (joy_load !== 1'b0 && n < 20);
        m = 1;
        while (joy_load === 1'b0 && m < LIMIT) begin
            @(posedge clk);
            #1;
            if (joy_load === 1'b0) m++;
            else break;
        end
        n_cmp += 2;
        if (n != 1) begin n_fail++; $display("FAIL mid_load_start got=%0d exp=1", n); end
        if (m != 2 * CLK_DIV) begin n_fail++; $display("FAIL mid_load_len got=%0d exp=%0d", m, 2 * CLK_DIV); end
        run_frame(pat, n, ok);
        n_cmp += 3;
        if (!ok) begin n_fail++; $display("FAIL mid_timeout got=none exp=frame_done"); end
        if (joystick1 !== exp_word(0)) begin n_fail++; $display("FAIL mid_next_j1 got=%h exp=%h", joystick1, exp_word(0)); end
        if (joystick2 !== exp_word(1)) begin n_fail++; $display("FAIL mid_next_j2 got=%h exp=%h", joystick2, exp_word(1)); end
    endtask

    task automatic test_clock_shape();
        int rises = 0, loadlow = 0, hi = 0, lo = 0, hi_bad = 0, lo_bad = 0, n = 0;
        logic prev;
        prev = joy_clk;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (joy_load === 1'b0) loadlow++;
            if (joy_clk && !prev) begin
                rises++;
                if (rises > 1 && lo != CLK_DIV) lo_bad++;
                hi = 0;
            end
            if (!joy_clk && prev) begin
                if (hi != CLK_DIV) hi_bad++;
                lo = 0;
            end
            if (joy_clk) hi++;
            else lo++;
            prev = joy_clk;
        end while (frame_done !== 1'b1 && n < LIMIT);
        n_cmp += 4;
        if (rises != NBITS)         begin n_fail++; $display("FAIL shape_rises got=%0d exp=%0d", rises, NBITS); end
        if (loadlow != 2 * CLK_DIV) begin n_fail++; $display("FAIL shape_load_low got=%0d exp=%0d", loadlow, 2 * CLK_DIV); end
        if (hi_bad != 0)            begin n_fail++; $display("FAIL shape_high_runs got=%0d bad exp=0", hi_bad); end
        if (lo_bad != 0)            begin n_fail++; $display("FAIL shape_low_runs got=%0d bad exp=0", lo_bad); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_released();
        test_single_press();
        test_stuck_pins();
        test_debounce();
        test_random();
        test_reset_mid_shift();
        test_clock_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
